mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single 32-bit memory port of the pipeline between the instruction-fetch stage and the MEM-stage data access.
- Drives the select line of the 32-bit 2:1 address mux in front of the memory.
- Sequences each access with a request/ready handshake and routes read data back to the winning requester.
- Generates a pipeline stall, a fairness limit and an access timeout.

Parameters:
- MAX_D_RUN, 4: maximum consecutive data grants while a fetch is pending; must be at least 1.
- TIMEOUT, 255: maximum cycles mem_req may stay high without mem_ready; 0 disables the timeout.
- TW, 8: width of the wait counter; must hold TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request, level
- d_req  in  1  data request, level
- d_we  in  1  data write enable, sampled at grant
- mem_ready  in  1  memory completes the access this cycle
- mem_rdata  in  32  memory read data, valid when mem_ready=1
- mem_req  out  1  memory access request, registered
- mem_we  out  1  memory write enable, registered
- addr_sel  out  1  address mux select: 0 = fetch address, 1 = data address; registered
- if_done  out  1  one-cycle fetch completion pulse
- if_rdata  out  32  last fetched word
- d_done  out  1  one-cycle data completion pulse
- d_rdata  out  32  last data read word
- err  out  1  one-cycle pulse on timeout abort, coincides with that requester's done
- pipe_stall  out  1  combinational: (if_req & ~if_done) | (d_req & ~d_done)

Behaviour:
- Reset (asynchronous, rst_n=0): all of the following clear immediately.
  - State goes to IDLE.
  - mem_req, mem_we, addr_sel, if_done, d_done and err go to 0.
  - if_rdata and d_rdata go to 0.
  - run_cnt and wait_cnt go to 0.
  - An access in flight is dropped and no done pulse is issued.
- States: IDLE, IF_ACC, D_ACC.
- Masking: in IDLE, a requester whose done is high in the current cycle is treated as not requesting. This gives the requester one cycle to drop req.
- Grant decision in IDLE, evaluated at the clock edge:
  - D_ACC if d_req (masked) and (run_cnt < MAX_D_RUN or if_req masked low).
  - Otherwise IF_ACC if if_req (masked).
  - Otherwise stay in IDLE.
- On a grant:
  - mem_req goes to 1.
  - addr_sel goes to 1 for D_ACC, 0 for IF_ACC.
  - mem_we takes d_we for D_ACC, 0 for IF_ACC.
  - wait_cnt goes to 0.
  - All of these stay stable for the whole access.
- run_cnt update:
  - On a D grant: if if_req=1, run_cnt = min(run_cnt+1, MAX_D_RUN); otherwise run_cnt = 0.
  - On an IF grant: run_cnt = 0.
- In IF_ACC or D_ACC:
  - mem_ready=1 at the edge: capture mem_rdata into the owner's rdata register (only if it is a read). Go to IDLE, drop mem_req, mem_we and addr_sel to 0, and pulse the owner's done for the next cycle.
  - mem_ready=0 and (TIMEOUT=0 or wait_cnt < TIMEOUT-1): increment wait_cnt and stay.
  - mem_ready=0 and wait_cnt == TIMEOUT-1: abort. Go to IDLE, drop mem_req, pulse the owner's done together with err, and leave rdata unchanged.
- Requests are not cancellable: dropping req during an access does not stop it, and done still pulses.
- Latency: req high in IDLE, then 1 cycle later mem_req is high. With zero-wait memory, done is high 2 cycles after the req cycle.
- rdata registers hold their value until the same requester's next successful read.
- if_done, d_done and err are never high for both requesters in the same cycle.

Test Plan:
1. Reset then single fetch with zero-wait memory, mem_rdata=0x00000013:
   - Required: mem_req high in cycle 1 with addr_sel=0.
   - Required: if_done pulse in cycle 2 and if_rdata=0x00000013.
   - Required: pipe_stall high in cycle 0 and cycle 1, low in cycle 2.
2. if_req and d_req both raised in the same cycle:
   - Required: data granted first with addr_sel=1.
   - Required: d_done, then the fetch grant follows in the cycle after d_done.
3. Fairness: d_req held high with 6 back-to-back reads while if_req is high, MAX_D_RUN=4:
   - Required grant order: D, D, D, D, IF, D, D.
   - Required: run_cnt resets to 0 after the IF grant.
4. Data write (d_we=1, mem_ready delayed 3 cycles):
   - Required: mem_we=1 and addr_sel=1 held for all 4 mem_req cycles.
   - Required: d_done one cycle after mem_ready; d_rdata unchanged.
5. Timeout with TIMEOUT=5 and mem_ready never asserted:
   - Required: mem_req high for exactly 5 cycles, then if_done and err pulse together.
   - Required: if_rdata unchanged and the next request is granted normally.
6. rst_n pulled low in the middle of D_ACC:
   - Required: mem_req, addr_sel and mem_we go to 0 immediately and no d_done is issued.
   - Required: after release, a pending d_req is granted from IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and MEM-stage data access,
// with a bounded data run while a fetch is pending and an access timeout.
module mem_port_arbiter #(
    parameter int MAX_D_RUN = 4,
    parameter int TIMEOUT   = 255,
    parameter int TW        = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic        d_req,
    input  logic        d_we,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic        if_done,
    output logic [31:0] if_rdata,
    output logic        d_done,
    output logic [31:0] d_rdata,
    output logic        err,
    output logic        pipe_stall
);

    localparam int RW = $clog2(MAX_D_RUN + 1);

    typedef enum logic [1:0] {
        IDLE,
        IF_ACC,
        D_ACC
    } state_t;

    state_t        state, state_nxt;
    logic [RW-1:0] run_cnt, run_cnt_nxt;
    logic [TW-1:0] wait_cnt, wait_cnt_nxt;
    logic          mem_req_nxt, mem_we_nxt, addr_sel_nxt;
    logic          if_done_nxt, d_done_nxt, err_nxt;
    logic [31:0]   if_rdata_nxt, d_rdata_nxt;
    logic          if_m, d_m, d_win, timed_out;

    // A requester completing this cycle is ignored so it has one cycle to drop req.
    assign if_m      = if_req & ~if_done;
    assign d_m       = d_req & ~d_done;
    assign d_win     = d_m & ((run_cnt < RW'(MAX_D_RUN)) | ~if_m);
    assign timed_out = (TIMEOUT != 0) && (wait_cnt == TW'(TIMEOUT - 1));

    assign pipe_stall = (if_req & ~if_done) | (d_req & ~d_done);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            run_cnt  <= '0;
            wait_cnt <= '0;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            addr_sel <= 1'b0;
            if_done  <= 1'b0;
            d_done   <= 1'b0;
            err      <= 1'b0;
            if_rdata <= '0;
            d_rdata  <= '0;
        end else begin
            state    <= state_nxt;
            run_cnt  <= run_cnt_nxt;
            wait_cnt <= wait_cnt_nxt;
            mem_req  <= mem_req_nxt;
            mem_we   <= mem_we_nxt;
            addr_sel <= addr_sel_nxt;
            if_done  <= if_done_nxt;
            d_done   <= d_done_nxt;
            err      <= err_nxt;
            if_rdata <= if_rdata_nxt;
            d_rdata  <= d_rdata_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        run_cnt_nxt  = run_cnt;
        wait_cnt_nxt = wait_cnt;
        mem_req_nxt  = mem_req;
        mem_we_nxt   = mem_we;
        addr_sel_nxt = addr_sel;
        if_done_nxt  = 1'b0;
        d_done_nxt   = 1'b0;
        err_nxt      = 1'b0;
        if_rdata_nxt = if_rdata;
        d_rdata_nxt  = d_rdata;

        case (state)
            IDLE: begin
                if (d_win) begin
                    state_nxt    = D_ACC;
                    mem_req_nxt  = 1'b1;
                    addr_sel_nxt = 1'b1;
                    mem_we_nxt   = d_we;
                    wait_cnt_nxt = '0;
                    if (if_req) begin
                        if (run_cnt != RW'(MAX_D_RUN)) begin
                            run_cnt_nxt = run_cnt + RW'(1);
                        end
                    end else begin
                        run_cnt_nxt = '0;
                    end
                end else if (if_m) begin
                    state_nxt    = IF_ACC;
                    mem_req_nxt  = 1'b1;
                    addr_sel_nxt = 1'b0;
                    mem_we_nxt   = 1'b0;
                    wait_cnt_nxt = '0;
                    run_cnt_nxt  = '0;
                end
            end

            IF_ACC, D_ACC: begin
                if (mem_ready || timed_out) begin
                    state_nxt    = IDLE;
                    mem_req_nxt  = 1'b0;
                    mem_we_nxt   = 1'b0;
                    addr_sel_nxt = 1'b0;
                    err_nxt      = ~mem_ready;
                    if (state == IF_ACC) begin
                        if_done_nxt = 1'b1;
                        if (mem_ready) begin
                            if_rdata_nxt = mem_rdata;
                        end
                    end else begin
                        d_done_nxt = 1'b1;
                        if (mem_ready && !mem_we) begin
                            d_rdata_nxt = mem_rdata;
                        end
                    end
                end else begin
                    wait_cnt_nxt = wait_cnt + TW'(1);
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: completion scoreboard, transaction table
// and cycle-exact sequences for latency, priority, fairness, write, timeout and reset.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, d_req, d_we, mem_ready;
    logic [31:0] mem_rdata;
    logic        mem_req, mem_we, addr_sel, if_done, d_done, err, pipe_stall;
    logic [31:0] if_rdata, d_rdata;

    logic        if_lvl;
    logic        fair_mode;
    logic [31:0] if_word, d_word;
    int          lat_cfg;
    int          wcnt;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit          is_d;
        bit          err;
        logic [31:0] rdata;
    } sb_t;

    typedef struct {
        bit          is_d;
        bit          we;
        int          lat;
        logic [31:0] word;
        logic [31:0] exp_rdata;
    } vec_t;

    sb_t  sb[$];
    bit   grants[$];
    vec_t vecs[5];

    mem_port_arbiter #(
        .MAX_D_RUN(4),
        .TIMEOUT  (5),
        .TW       (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .d_req     (d_req),
        .d_we      (d_we),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .addr_sel  (addr_sel),
        .if_done   (if_done),
        .if_rdata  (if_rdata),
        .d_done    (d_done),
        .d_rdata   (d_rdata),
        .err       (err),
        .pipe_stall(pipe_stall)
    );

    always #5 clk = ~clk;

    // Fetch requester that withdraws while a data access completes (exposes the run limit).
    assign if_req = if_lvl & ~(fair_mode & d_done);

    // Memory model: ready after lat_cfg wait cycles of mem_req.
    always @(posedge clk) begin
        if (mem_req && !mem_ready) wcnt <= wcnt + 1;
        else                       wcnt <= 0;
    end
    assign mem_ready = mem_req && (wcnt == lat_cfg);
    assign mem_rdata = addr_sel ? d_word : if_word;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic push_exp(input bit is_d, input bit e_err, input logic [31:0] rd);
        sb_t e;
        e.is_d  = is_d;
        e.err   = e_err;
        e.rdata = rd;
        sb.push_back(e);
    endtask

    task automatic monitor();
        sb_t  e;
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (mem_req && !prev) grants.push_back(addr_sel);
                if (if_done || d_done || err) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL sb_unexpected: if_done=%b d_done=%b err=%b expected no completion",
                                 if_done, d_done, err);
                    end else begin
                        e = sb.pop_front();
                        check("sb_owner", {30'b0, if_done, d_done}, e.is_d ? 32'd1 : 32'd2);
                        check("sb_err", {31'b0, err}, {31'b0, e.err});
                        check("sb_rdata", e.is_d ? d_rdata : if_rdata, e.rdata);
                    end
                end
            end
            prev = mem_req;
        end
    endtask

    task automatic wait_done(input bit is_d, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(is_d ? d_done : if_done) && n < budget);
        if (!(is_d ? d_done : if_done)) begin
            checks++;
            failures++;
            $display("FAIL wait_done: no done for is_d=%0d within %0d cycles", is_d, budget);
        end
    endtask

    task automatic do_acc(input bit is_d, input bit we, input int lat, input logic [31:0] word,
                          input logic [31:0] exp_rd, input bit exp_err);
        lat_cfg = lat;
        if (is_d) begin
            d_word = word;
            d_we   = we;
            d_req  = 1'b1;
        end else begin
            if_word = word;
            if_lvl  = 1'b1;
        end
        push_exp(is_d, exp_err, exp_rd);
        wait_done(is_d, 40);
        @(posedge clk); #1;
        if (is_d) begin
            d_req = 1'b0;
            d_we  = 1'b0;
        end else begin
            if_lvl = 1'b0;
        end
    endtask

    initial begin
        int        n, dn, cyc;
        bit        seen_if, got_done, prev_rdy;
        logic [6:0] ord;

        rst_n = 1'b0; if_lvl = 1'b0; d_req = 1'b0; d_we = 1'b0; fair_mode = 1'b0;
        if_word = '0; d_word = '0; lat_cfg = 0;
        vecs[0] = '{1'b0, 1'b0, 1, 32'h0000_1111, 32'h0000_1111};
        vecs[1] = '{1'b1, 1'b0, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[2] = '{1'b1, 1'b1, 2, 32'h5555_0000, 32'hDEAD_BEEF};
        vecs[3] = '{1'b0, 1'b0, 4, 32'h0BAD_F00D, 32'h0BAD_F00D};
        vecs[4] = '{1'b1, 1'b0, 3, 32'h1234_5678, 32'h1234_5678};

        fork
            monitor();
        join_none

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_ctrl", {25'b0, mem_req, mem_we, addr_sel, if_done, d_done, err, pipe_stall}, 32'd0);
        check("reset_if_rdata", if_rdata, 32'd0);
        check("reset_d_rdata", d_rdata, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single fetch, zero wait: cycle-exact latency and stall
        if_word = 32'h0000_0013; lat_cfg = 0; if_lvl = 1'b1;
        push_exp(1'b0, 1'b0, 32'h0000_0013);
        @(negedge clk);
        check("t1_c0_stall", {30'b0, pipe_stall, mem_req}, 32'd2);
        @(negedge clk);
        check("t1_c1_req_sel", {29'b0, mem_req, addr_sel, pipe_stall}, 32'd5);
        @(negedge clk);
        check("t1_c2_done_stall", {30'b0, if_done, pipe_stall}, 32'd2);
        check("t1_c2_rdata", if_rdata, 32'h0000_0013);
        @(posedge clk); #1;
        if_lvl = 1'b0;

        // Transaction table
        for (int i = 0; i < 5; i++) begin
            do_acc(vecs[i].is_d, vecs[i].we, vecs[i].lat, vecs[i].word, vecs[i].exp_rdata, 1'b0);
        end

        // Simultaneous requests: data first, fetch right after d_done
        lat_cfg = 0; d_word = 32'hA5A5_0002; if_word = 32'h0000_0002;
        push_exp(1'b1, 1'b0, 32'hA5A5_0002);
        push_exp(1'b0, 1'b0, 32'h0000_0002);
        d_req = 1'b1; if_lvl = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t2_d_first", {30'b0, mem_req, addr_sel}, 32'd3);
        wait_done(1'b1, 20);
        @(posedge clk); #1;
        d_req = 1'b0;
        @(negedge clk);
        check("t2_if_after_d_done", {30'b0, mem_req, addr_sel}, 32'd2);
        wait_done(1'b0, 20);
        @(posedge clk); #1;
        if_lvl = 1'b0;

        // Fairness: run limit forces the fetch in after four data grants
        fair_mode = 1'b1; grants.delete(); lat_cfg = 0;
        d_word = 32'h0000_00D3; if_word = 32'h0000_0F03;
        for (int k = 0; k < 4; k++) push_exp(1'b1, 1'b0, 32'h0000_00D3);
        push_exp(1'b0, 1'b0, 32'h0000_0F03);
        for (int k = 0; k < 2; k++) push_exp(1'b1, 1'b0, 32'h0000_00D3);
        d_req = 1'b1; if_lvl = 1'b1;
        dn = 0; n = 0; seen_if = 1'b0;
        while (dn < 6 && n < 150) begin
            @(negedge clk);
            n++;
            if (mem_req && !addr_sel && !seen_if) begin
                check("t3_run_cnt_after_if", 32'(dut.run_cnt), 32'd0);
                seen_if = 1'b1;
            end
            if (if_done) if_lvl = 1'b0;
            if (d_done) begin
                dn++;
                if (dn == 4) check("t3_run_cnt_sat", 32'(dut.run_cnt), 32'd4);
                if (dn == 6) d_req = 1'b0;
            end
        end
        check("t3_d_done_count", dn, 32'd6);
        @(posedge clk); #1;
        fair_mode = 1'b0;
        ord = 7'b110_1111;
        check("t3_grant_count", grants.size(), 32'd7);
        for (int i = 0; i < 7; i++) begin
            if (i < grants.size()) check($sformatf("t3_grant_%0d", i), {31'b0, grants[i]}, {31'b0, ord[i]});
        end

        // Data write with 3 wait cycles
        lat_cfg = 3; d_word = 32'hFFFF_FFFF; d_we = 1'b1; d_req = 1'b1;
        push_exp(1'b1, 1'b0, 32'h0000_00D3);
        cyc = 0; n = 0; got_done = 1'b0; prev_rdy = 1'b0;
        while (!got_done && n < 30) begin
            @(negedge clk);
            n++;
            if (mem_req) begin
                cyc++;
                check("t4_we_sel", {30'b0, mem_we, addr_sel}, 32'd3);
                d_we = 1'b0;
            end
            if (d_done) begin
                got_done = 1'b1;
                check("t4_done_after_ready", {31'b0, prev_rdy}, 32'd1);
                check("t4_req_cycles", cyc, 32'd4);
            end
            prev_rdy = mem_ready;
        end
        check("t4_done_seen", {31'b0, got_done}, 32'd1);
        @(posedge clk); #1;
        d_req = 1'b0;

        // Timeout abort after 5 cycles, then a normal fetch
        lat_cfg = 1000; if_word = 32'hEEEE_EEEE; if_lvl = 1'b1;
        push_exp(1'b0, 1'b1, 32'h0000_0F03);
        cyc = 0; n = 0; got_done = 1'b0;
        while (!got_done && n < 30) begin
            @(negedge clk);
            n++;
            if (mem_req) cyc++;
            if (if_done) begin
                got_done = 1'b1;
                check("t5_err_with_done", {31'b0, err}, 32'd1);
                check("t5_req_cycles", cyc, 32'd5);
            end
        end
        check("t5_done_seen", {31'b0, got_done}, 32'd1);
        @(posedge clk); #1;
        if_lvl = 1'b0;
        do_acc(1'b0, 1'b0, 0, 32'h0000_0F05, 32'h0000_0F05, 1'b0);

        // Reset in the middle of a data access
        lat_cfg = 4; d_word = 32'h0BAD_0BAD; d_we = 1'b1; d_req = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_req && n < 10);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6_rst_drop", {29'b0, mem_req, addr_sel, mem_we}, 32'd0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("t6_rst_no_done", {29'b0, d_done, if_done, err}, 32'd0);
        end
        check("t6_rst_if_rdata", if_rdata, 32'd0);
        check("t6_rst_d_rdata", d_rdata, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; d_we = 1'b0; d_word = 32'h0000_0006; lat_cfg = 0;
        push_exp(1'b1, 1'b0, 32'h0000_0006);
        wait_done(1'b1, 20);
        @(posedge clk); #1;
        d_req = 1'b0;

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
